// File: rtl/packed_struct_walker_tx_if.sv
// Bundle of the record-load handshake and the element-beat stream for
// packed_struct_walker_tx. The walker uses the master view; the producer/sink
// side (or a bench) uses the slave view.
interface packed_struct_walker_tx_if #(
    parameter int W       = 4,
    parameter int IDX_W   = 4,
    parameter int TOTAL_W = 221
);
    logic               in_valid;
    logic               in_ready;
    logic [TOTAL_W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_tag;
    logic [IDX_W-1:0]   out_idx0;
    logic [IDX_W-1:0]   out_idx1;
    logic [W-1:0]       out_data;
    logic               out_t;
    logic               out_first;
    logic               out_last;

    modport master (
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_tag,
        output out_idx0,
        output out_idx1,
        output out_data,
        output out_t,
        output out_first,
        output out_last
    );

    modport slave (
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_tag,
        input  out_idx0,
        input  out_idx1,
        input  out_data,
        input  out_t,
        input  out_first,
        input  out_last
    );
endinterface

// File: rtl/packed_struct_walker_tx.sv
// Transmit-side walker for the packed record {t, x, y[2:7], z[7:2][2:9]}.
// A whole record is captured on load, then emitted one 4-bit element per beat:
// header (t and x), every y element, then every z element outer-major. Each
// dimension is walked from its $left to its $right so a receiver can rebuild
// the record from tags and indices alone. All beat outputs are registered and
// computed from the next walk position, so the header appears the cycle after
// load and a stalled beat is held simply because the position does not move.
module packed_struct_walker_tx #(
    parameter int W       = 4,
    parameter int NY      = 6,
    parameter int Y_LEFT  = 2,
    parameter int NZ1     = 6,
    parameter int Z1_LEFT = 7,
    parameter int NZ2     = 8,
    parameter int Z2_LEFT = 2,
    parameter int IDX_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    packed_struct_walker_tx_if.master bus
);

    localparam int TOTAL_W = 1 + W + NY * W + NZ1 * NZ2 * W;
    localparam int YC_W    = (NY  > 1) ? $clog2(NY)  : 1;
    localparam int P_W     = (NZ1 > 1) ? $clog2(NZ1) : 1;
    localparam int Q_W     = (NZ2 > 1) ? $clog2(NZ2) : 1;

    localparam logic [YC_W-1:0] Y_LAST = YC_W'(NY - 1);
    localparam logic [P_W-1:0]  P_LAST = P_W'(NZ1 - 1);
    localparam logic [Q_W-1:0]  Q_LAST = Q_W'(NZ2 - 1);

    localparam logic [1:0] TAG_HDR = 2'd0;
    localparam logic [1:0] TAG_Y   = 2'd1;
    localparam logic [1:0] TAG_Z   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_Y    = 2'd2,
        ST_Z    = 2'd3
    } state_t;

    // Walk position and captured record
    state_t             state_q, state_d;
    logic [YC_W-1:0]    ycnt_q,  ycnt_d;
    logic [P_W-1:0]     p_q,     p_d;
    logic [Q_W-1:0]     q_q,     q_d;
    logic [TOTAL_W-1:0] rec_q,   rec_d;

    // Registered beat outputs
    logic               out_valid_q, out_valid_d;
    logic [1:0]         out_tag_q,   out_tag_d;
    logic [IDX_W-1:0]   out_idx0_q,  out_idx0_d;
    logic [IDX_W-1:0]   out_idx1_q,  out_idx1_d;
    logic [W-1:0]       out_data_q,  out_data_d;
    logic               out_t_q,     out_t_d;
    logic               out_first_q, out_first_d;
    logic               out_last_q,  out_last_d;

    logic in_ready_s;
    logic load_s;
    logic advance_s;
    int   y_shift_s;
    int   z_shift_s;

    // Load is only possible from IDLE and never during reset
    assign in_ready_s = (state_q == ST_IDLE) && !rst;
    assign load_s     = bus.in_valid && in_ready_s;
    assign advance_s  = out_valid_q && bus.out_ready;

    // Next walk position: advance on each accepted beat, wrap inner before outer
    always_comb begin
        state_d = state_q;
        ycnt_d  = ycnt_q;
        p_d     = p_q;
        q_d     = q_q;
        rec_d   = rec_q;
        case (state_q)
            ST_IDLE: begin
                if (load_s) begin
                    state_d = ST_HDR;
                    rec_d   = bus.in_data;
                    ycnt_d  = {YC_W{1'b0}};
                    p_d     = {P_W{1'b0}};
                    q_d     = {Q_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (advance_s) begin
                    state_d = ST_Y;
                    ycnt_d  = {YC_W{1'b0}};
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_Y: begin
                if (advance_s) begin
                    if (ycnt_q == Y_LAST) begin
                        state_d = ST_Z;
                        ycnt_d  = {YC_W{1'b0}};
                        p_d     = {P_W{1'b0}};
                        q_d     = {Q_W{1'b0}};
                    end else begin
                        ycnt_d = ycnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_Y;
                end
            end
            ST_Z: begin
                if (advance_s) begin
                    if (q_q == Q_LAST) begin
                        q_d = {Q_W{1'b0}};
                        if (p_q == P_LAST) begin
                            state_d = ST_IDLE;
                            p_d     = {P_W{1'b0}};
                        end else begin
                            p_d = p_q + 1'b1;
                        end
                    end else begin
                        q_d = q_q + 1'b1;
                    end
                end else begin
                    state_d = ST_Z;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ycnt_d  = {YC_W{1'b0}};
                p_d     = {P_W{1'b0}};
                q_d     = {Q_W{1'b0}};
            end
        endcase
    end

    // Element bit offsets of the next y and z positions inside the record
    always_comb begin
        y_shift_s = TOTAL_W - 1 - W - (int'(ycnt_d) + 1) * W;
        z_shift_s = (NZ1 * NZ2 - 1 - (int'(p_d) * NZ2 + int'(q_d))) * W;
    end

    // Beat contents for the next walk position
    always_comb begin
        out_valid_d = 1'b0;
        out_tag_d   = TAG_HDR;
        out_idx0_d  = {IDX_W{1'b0}};
        out_idx1_d  = {IDX_W{1'b0}};
        out_data_d  = {W{1'b0}};
        out_t_d     = 1'b0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
        case (state_d)
            ST_IDLE: begin
                out_valid_d = 1'b0;
            end
            ST_HDR: begin
                out_valid_d = 1'b1;
                out_tag_d   = TAG_HDR;
                out_data_d  = W'(rec_d >> (TOTAL_W - 1 - W));
                out_t_d     = rec_d[TOTAL_W-1];
                out_first_d = 1'b1;
            end
            ST_Y: begin
                out_valid_d = 1'b1;
                out_tag_d   = TAG_Y;
                out_idx0_d  = IDX_W'(Y_LEFT + int'(ycnt_d));
                out_data_d  = W'(rec_d >> y_shift_s);
            end
            ST_Z: begin
                out_valid_d = 1'b1;
                out_tag_d   = TAG_Z;
                out_idx0_d  = IDX_W'(Z1_LEFT - int'(p_d));
                out_idx1_d  = IDX_W'(Z2_LEFT + int'(q_d));
                out_data_d  = W'(rec_d >> z_shift_s);
                out_last_d  = (p_d == P_LAST) && (q_d == Q_LAST);
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, position, record and beat registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ycnt_q      <= {YC_W{1'b0}};
            p_q         <= {P_W{1'b0}};
            q_q         <= {Q_W{1'b0}};
            rec_q       <= {TOTAL_W{1'b0}};
            out_valid_q <= 1'b0;
            out_tag_q   <= 2'd0;
            out_idx0_q  <= {IDX_W{1'b0}};
            out_idx1_q  <= {IDX_W{1'b0}};
            out_data_q  <= {W{1'b0}};
            out_t_q     <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ycnt_q      <= ycnt_d;
            p_q         <= p_d;
            q_q         <= q_d;
            rec_q       <= rec_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_idx0_q  <= out_idx0_d;
            out_idx1_q  <= out_idx1_d;
            out_data_q  <= out_data_d;
            out_t_q     <= out_t_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_idx0  = out_idx0_q;
    assign bus.out_idx1  = out_idx1_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_t     = out_t_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_packed_struct_walker_tx.sv
// Self-checking bench for packed_struct_walker_tx. The reference model decodes
// each record through a packed struct with the same declared ranges and lists
// the expected beats by looping each dimension from $left to $right.
module tb_packed_struct_walker_tx;

    localparam int TW = 221;

    typedef struct packed {
        logic                   t;
        logic [3:0]             x;
        logic [2:7][3:0]        y;
        logic [7:2][2:9][3:0]   z;
    } rec_t;

    logic clk;
    logic rst;

    packed_struct_walker_tx_if #(.W(4), .IDX_W(4), .TOTAL_W(TW)) bus ();

    packed_struct_walker_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_q[$];
    logic [16:0] got_log[0:63];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {tag, idx0, idx1, data, t, first, last}
    function automatic logic [16:0] beat_vec();
        return {bus.out_tag, bus.out_idx0, bus.out_idx1, bus.out_data,
                bus.out_t, bus.out_first, bus.out_last};
    endfunction

    task automatic build_expected(input logic [TW-1:0] rec);
        rec_t r;
        r = rec;
        exp_q.push_back({2'd0, 4'd0, 4'd0, r.x, r.t, 1'b1, 1'b0});
        for (int i = 2; i <= 7; i++)
            exp_q.push_back({2'd1, 4'(i), 4'd0, r.y[i], 1'b0, 1'b0, 1'b0});
        for (int o = 7; o >= 2; o--)
            for (int m = 2; m <= 9; m++)
                exp_q.push_back({2'd2, 4'(o), 4'(m), r.z[o][m], 1'b0, 1'b0,
                                 1'((o == 2) && (m == 9))});
    endtask

    function automatic logic [TW-1:0] rand_rec();
        logic [TW-1:0] v;
        for (int i = 0; i < TW; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Wait for in_ready, present the record for one edge, expect HDR next
    task automatic load_record(input logic [TW-1:0] rec, input bit hold_valid);
        int budget;
        budget = 100;
        while (!bus.in_ready && budget > 0) begin
            tick();
            budget--;
        end
        check_eq("load_ready_timeout", 32'(budget == 0), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = rec;
        build_expected(rec);
        tick();
        if (!hold_valid) bus.in_valid = 1'b0;
        check_eq("load_valid", 32'(bus.out_valid), 32'd1);
    endtask

    // Consume beats with random readiness; stop_after > 0 ends early
    task automatic drain(input int rdy_pct, input int stop_after, output int n_hs);
        int budget, firsts, lasts, bad_tag;
        logic [16:0] cur, prev, exp;
        bit prev_stall, done, rdy;
        n_hs = 0; firsts = 0; lasts = 0; bad_tag = 0;
        prev = 17'd0; prev_stall = 1'b0; done = 1'b0; budget = 4000;
        while (!done && budget > 0) begin
            cur = beat_vec();
            if (prev_stall) begin
                check_eq("stall_hold", 32'(cur), 32'(prev));
                check_eq("stall_valid", 32'(bus.out_valid), 32'd1);
            end
            if (bus.out_valid && bus.out_tag == 2'd3) bad_tag++;
            rdy = ($urandom_range(0, 99) < rdy_pct);
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
                check_eq("beat_overrun", 32'(exp_q.size() == 0), 32'd0);
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 17'd0;
                check_eq($sformatf("beat%0d", n_hs), 32'(cur), 32'(exp));
                if (n_hs < 64) got_log[n_hs] = cur;
                n_hs++;
                firsts += int'(cur[1]);
                lasts  += int'(cur[0]);
                if (cur[0]) done = 1'b1;
            end
            prev_stall = bus.out_valid && !rdy;
            prev = cur;
            tick();
            budget--;
            if (stop_after > 0 && n_hs == stop_after) done = 1'b1;
        end
        bus.out_ready = 1'b0;
        check_eq("drain_timeout", 32'(!done), 32'd0);
        if (stop_after == 0) begin
            check_eq("hs_count", 32'(n_hs), 32'd55);
            check_eq("first_count", 32'(firsts), 32'd1);
            check_eq("last_count", 32'(lasts), 32'd1);
            check_eq("tag3_seen", 32'(bad_tag), 32'd0);
            check_eq("exp_left", 32'(exp_q.size()), 32'd0);
            check_eq("idle_after_last", 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [TW-1:0] rec1, recb;
        int n;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = {TW{1'b0}};
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_beat", 32'(beat_vec()), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed record: t=1, x=A, y=1..6, z=incrementing nibbles
        rec1 = {TW{1'b0}};
        rec1[220]     = 1'b1;
        rec1[219:216] = 4'hA;
        for (int r = 0; r < 6; r++) rec1[215 - 4 * r -: 4] = 4'(r + 1);
        for (int k = 0; k < 48; k++) rec1[191 - 4 * k -: 4] = 4'(k);
        load_record(rec1, 1'b0);
        drain(100, 0, n);
        check_eq("b0", 32'(got_log[0]), 32'({2'd0, 4'd0, 4'd0, 4'hA, 1'b1, 1'b1, 1'b0}));
        check_eq("b1_tag", 32'(got_log[1][16:15]), 32'd1);
        check_eq("b1_idx0", 32'(got_log[1][14:11]), 32'd2);
        check_eq("b1_data", 32'(got_log[1][6:3]), 32'(rec1[215:212]));
        check_eq("b6_idx0", 32'(got_log[6][14:11]), 32'd7);
        check_eq("b7_tag", 32'(got_log[7][16:15]), 32'd2);
        check_eq("b7_idx", 32'(got_log[7][14:7]), 32'h72);
        check_eq("b7_data", 32'(got_log[7][6:3]), 32'(rec1[191:188]));
        check_eq("b14_idx", 32'(got_log[14][14:7]), 32'h79);
        check_eq("b15_idx", 32'(got_log[15][14:7]), 32'h62);
        check_eq("b54_idx", 32'(got_log[54][14:7]), 32'h29);
        check_eq("b54_data", 32'(got_log[54][6:3]), 32'(rec1[3:0]));
        check_eq("b54_last", 32'(got_log[54][1:0]), 32'd1);

        // Random record, sink ready about 30% of cycles
        load_record(rand_rec(), 1'b0);
        drain(30, 0, n);

        // in_valid held high across two records; second must wait for IDLE
        recb = rand_rec();
        load_record(rand_rec(), 1'b1);
        bus.in_data = recb;
        drain(70, 0, n);
        check_eq("bubble_in_ready", 32'(bus.in_ready), 32'd1);
        build_expected(recb);
        tick();
        bus.in_valid = 1'b0;
        check_eq("second_hdr_valid", 32'(bus.out_valid), 32'd1);
        check_eq("second_hdr_first", 32'(bus.out_first), 32'd1);
        drain(100, 0, n);

        // Reset in the middle of a record
        load_record(rand_rec(), 1'b0);
        drain(100, 20, n);
        check_eq("pre_rst_hs", 32'(n), 32'd20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_beat", 32'(beat_vec()), 32'd0);
        check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        load_record(rand_rec(), 1'b0);
        drain(60, 0, n);

        // A few more random records with varied sink readiness
        for (int i = 0; i < 3; i++) begin
            load_record(rand_rec(), 1'b0);
            drain(int'($urandom_range(20, 100)), 0, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
